// File: rtl/ro_puf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ro_puf_ctrl_pkg
// Shared definitions for the ring-oscillator PUF controller:
//   - FSM state encoding
//   - default settle length and edge-counter width
//   - challenge nibble field positions
//   - RO index helper (base + bit index, modulo 16)
// ---------------------------------------------------------------------------
package ro_puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        NEXT    = 3'd4,
        HOLD    = 3'd5
    } state_e;

    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_CNT_W      = 16;

    // challenge[7:4] is base index A, challenge[3:0] is base index B
    localparam int CH_W     = 8;
    localparam int NIB_W    = 4;
    localparam int CH_A_LSB = 4;
    localparam int CH_B_LSB = 0;

    // RO index for bit k; 4-bit arithmetic gives the modulo-16 wrap for free
    function automatic logic [NIB_W-1:0] ro_index(input logic [NIB_W-1:0] base,
                                                  input logic [NIB_W-1:0] k);
        return base + k;
    endfunction

endpackage

// File: rtl/ro_puf_ctrl_edge_cnt.sv
// ---------------------------------------------------------------------------
// ro_edge_cnt
// Synchronizes one asynchronous RO output (2 flops), detects rising edges
// and counts them in a saturating counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the counter (has priority over en)
//   en         : count enable
//   ro         : asynchronous oscillator output
//   count      : saturating rising-edge count
// ---------------------------------------------------------------------------
module ro_edge_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             ro,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // [0],[1]: synchronizer stages (sync_q = [1]); [2]: previous sync_q
    logic [2:0] sync_r;
    logic       edge_s;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], ro};
        end
    end

    assign edge_s = sync_r[1] & ~sync_r[2];

    // Saturating edge counter: holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (en && edge_s && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// ---------------------------------------------------------------------------
// ro_puf_ctrl
// Ring-oscillator PUF controller. For each of RESP_BITS response bits it
// selects an RO pair, lets it settle, counts edges of both ROs over a
// measurement window and sets the bit when RO A is faster than RO B.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, challenge   : request pulse (sampled in IDLE) and base indices
//   win_len            : measurement window in clk cycles (0 treated as 1)
//   ro_a, ro_b         : asynchronous outputs of the selected ROs
//   ro_en, sel_a, sel_b: oscillator enable and pair selects
//   busy               : high whenever not IDLE
//   resp, resp_valid   : response word and its valid flag (held in HOLD)
//   resp_ready         : consumer acceptance
//   tie                : sticky flag, some bit had equal counts
// All outputs are registered.
// ---------------------------------------------------------------------------
module ro_puf_ctrl
    import ro_puf_ctrl_pkg::*;
#(
    parameter int RESP_BITS  = 8,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CH_W-1:0]      challenge,
    input  logic [CNT_W-1:0]     win_len,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 ro_en,
    output logic [NIB_W-1:0]     sel_a,
    output logic [NIB_W-1:0]     sel_b,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie
);

    localparam int               K_W         = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [K_W-1:0]   K_LAST      = K_W'(RESP_BITS - 1);
    localparam logic [K_W-1:0]   K_ONE       = K_W'(1);
    localparam logic [CNT_W-1:0] T_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e               state_r, state_next_s;
    logic [K_W-1:0]       k_r, k_next_s;
    logic [CNT_W-1:0]     tmr_r, tmr_next_s;
    logic [CH_W-1:0]      ch_r, ch_next_s;
    logic [CNT_W-1:0]     win_r, win_next_s;
    logic [RESP_BITS-1:0] resp_next_s;
    logic                 tie_next_s;
    logic                 sel_drive_s;
    logic [NIB_W-1:0]     sel_a_next_s, sel_b_next_s;
    logic [CNT_W-1:0]     count_a, count_b;

    ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_r == SETTLE),
        .en    (state_r == MEASURE),
        .ro    (ro_a),
        .count (count_a)
    );

    ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_r == SETTLE),
        .en    (state_r == MEASURE),
        .ro    (ro_b),
        .count (count_b)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-datapath logic; outputs are registered from these
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        tmr_next_s   = tmr_r;
        ch_next_s    = ch_r;
        win_next_s   = win_r;
        resp_next_s  = resp;
        tie_next_s   = tie;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SETTLE;
                    k_next_s     = {K_W{1'b0}};
                    tmr_next_s   = {CNT_W{1'b0}};
                    ch_next_s    = challenge;
                    win_next_s   = (win_len == {CNT_W{1'b0}}) ? T_ONE : win_len;
                    resp_next_s  = {RESP_BITS{1'b0}};
                    tie_next_s   = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (tmr_r == SETTLE_LAST) begin
                    state_next_s = MEASURE;
                    tmr_next_s   = {CNT_W{1'b0}};
                end else begin
                    tmr_next_s   = tmr_r + T_ONE;
                end
            end
            MEASURE: begin
                if (tmr_r == (win_r - T_ONE)) begin
                    state_next_s = COMPARE;
                    tmr_next_s   = {CNT_W{1'b0}};
                end else begin
                    tmr_next_s   = tmr_r + T_ONE;
                end
            end
            COMPARE: begin
                resp_next_s[k_r] = (count_a > count_b);
                tie_next_s       = tie | (count_a == count_b);
                state_next_s     = NEXT;
            end
            NEXT: begin
                if (k_r == K_LAST) begin
                    state_next_s = HOLD;
                end else begin
                    k_next_s     = k_r + K_ONE;
                    state_next_s = SETTLE;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        // Pair selects are only meaningful while the pair is being measured
        sel_drive_s = (state_next_s == SETTLE) || (state_next_s == MEASURE) ||
                      (state_next_s == COMPARE);
        if (sel_drive_s) begin
            sel_a_next_s = ro_index(ch_next_s[CH_A_LSB +: NIB_W], NIB_W'(k_next_s));
            sel_b_next_s = ro_index(ch_next_s[CH_B_LSB +: NIB_W], NIB_W'(k_next_s));
        end else begin
            sel_a_next_s = {NIB_W{1'b0}};
            sel_b_next_s = {NIB_W{1'b0}};
        end
    end

    // Datapath and registered outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r        <= {K_W{1'b0}};
            tmr_r      <= {CNT_W{1'b0}};
            ch_r       <= {CH_W{1'b0}};
            win_r      <= {CNT_W{1'b0}};
            resp       <= {RESP_BITS{1'b0}};
            tie        <= 1'b0;
            ro_en      <= 1'b0;
            sel_a      <= {NIB_W{1'b0}};
            sel_b      <= {NIB_W{1'b0}};
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            k_r        <= k_next_s;
            tmr_r      <= tmr_next_s;
            ch_r       <= ch_next_s;
            win_r      <= win_next_s;
            resp       <= resp_next_s;
            tie        <= tie_next_s;
            ro_en      <= (state_next_s == SETTLE) || (state_next_s == MEASURE);
            sel_a      <= sel_a_next_s;
            sel_b      <= sel_b_next_s;
            busy       <= (state_next_s != IDLE);
            resp_valid <= (state_next_s == HOLD);
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_ctrl
// Self-checking bench for ro_puf_ctrl: table of challenge/stimulus records
// with expected response, tie and latency pushed to a scoreboard at start
// and popped when resp_valid appears; plus hand-written sequences for the
// HOLD handshake, reset mid-measurement and counter saturation.
// ---------------------------------------------------------------------------
module tb_ro_puf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  challenge;
    logic [15:0] win_len;
    logic        ro_a = 1'b0;
    logic        ro_b = 1'b0;
    logic        ro_en;
    logic [3:0]  sel_a, sel_b;
    logic        busy;
    logic [7:0]  resp;
    logic        resp_valid;
    logic        resp_ready;
    logic        tie;

    logic        sat_clr, sat_en, sat_ro;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ro_puf_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .challenge  (challenge),
        .win_len    (win_len),
        .ro_a       (ro_a),
        .ro_b       (ro_b),
        .ro_en      (ro_en),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .tie        (tie)
    );

    // Narrow stand-alone counter so saturation is reachable in a short run
    ro_edge_cnt #(.CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sat_clr),
        .en    (sat_en),
        .ro    (sat_ro),
        .count (sat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RO stimulus: toggle period in clk cycles, 0 = stuck low; same copies A to B
    int per_a = 0;
    int per_b = 0;
    bit same  = 1'b0;
    int ca = 0;
    int cb = 0;
    always @(negedge clk) begin
        if (per_a > 0) begin
            ca++;
            if (ca >= per_a) begin ca = 0; ro_a = ~ro_a; end
        end else begin
            ro_a = 1'b0;
        end
        if (same) begin
            ro_b = ro_a;
        end else if (per_b > 0) begin
            cb++;
            if (cb >= per_b) begin cb = 0; ro_b = ~ro_b; end
        end else begin
            ro_b = 1'b0;
        end
    end

    // Record the selected pair at each new measurement (ro_en rising)
    typedef struct packed { logic [3:0] a; logic [3:0] b; } sel_t;
    sel_t sel_q[$];
    logic en_prev   = 1'b0;
    int   en_rises  = 0;
    always @(negedge clk) begin
        if (ro_en && !en_prev) begin
            sel_q.push_back({sel_a, sel_b});
            en_rises++;
        end
        en_prev = ro_en;
    end

    typedef struct {
        logic [7:0]  ch;
        logic [15:0] win;
        int          pa;
        int          pb;
        bit          same;
        logic [7:0]  exp_resp;
        logic        exp_tie;
        int          hold;
    } vec_t;

    typedef struct {
        logic [7:0] resp;
        logic       tie;
        int         lat;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic run_vec(input vec_t v);
        int         weff;
        int         cyc;
        int         base;
        exp_t       e;
        exp_t       got;
        logic [7:0] r0;
        logic [3:0] ea, eb;
        per_a = v.pa;
        per_b = v.pb;
        same  = v.same;
        resp_ready = (v.hold == 0);
        repeat (3) @(posedge clk);
        #1;
        base   = sel_q.size();
        weff   = (v.win == 16'd0) ? 1 : int'(v.win);
        e.resp = v.exp_resp;
        e.tie  = v.exp_tie;
        e.lat  = 8 * (4 + weff + 2) + 1;
        sb.push_back(e);
        challenge = v.ch;
        win_len   = v.win;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        challenge = ~v.ch;          // later changes must not matter
        win_len   = 16'd5;
        cyc       = 1;
        chk("busy_after_start", busy, 1);
        chk("valid_low_after_start", resp_valid, 0);
        while (!resp_valid && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        got = sb.pop_front();
        if (!resp_valid) begin
            chk("resp_valid_timeout", 0, 1);
            return;
        end
        chk("latency", cyc, got.lat);
        chk("resp", resp, got.resp);
        chk("tie", tie, got.tie);
        chk("pairs_measured", sel_q.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < sel_q.size()) begin
                ea = v.ch[7:4] + 4'(k);
                eb = v.ch[3:0] + 4'(k);
                chk($sformatf("sel_a_bit%0d", k), sel_q[base + k].a, ea);
                chk($sformatf("sel_b_bit%0d", k), sel_q[base + k].b, eb);
            end
        end
        if (v.hold > 0) begin
            r0 = resp;
            for (int i = 0; i < v.hold; i++) begin
                if (i == 5) start = 1'b1;   // must be ignored in HOLD
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("hold_valid", resp_valid, 1);
                chk("hold_resp", resp, r0);
                chk("hold_busy", busy, 1);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid_drop", resp_valid, 0);
        chk("idle_busy", busy, 0);
        resp_ready = 1'b0;
    endtask

    initial begin
        int   base;
        int   cyc;
        int   bad;
        bit   wrapped;
        logic [3:0] prev;

        // ch,   win,     pa, pb, same, resp,  tie, hold
        vecs[0] = '{8'h12, 16'd100, 2, 5, 1'b0, 8'hFF, 1'b0, 20};
        vecs[1] = '{8'h33, 16'd20,  2, 0, 1'b1, 8'h00, 1'b1, 0};
        vecs[2] = '{8'hF0, 16'd30,  0, 3, 1'b0, 8'h00, 1'b0, 3};
        vecs[3] = '{8'h5A, 16'd10,  0, 0, 1'b0, 8'h00, 1'b1, 0};
        vecs[4] = '{8'hA5, 16'd0,   0, 0, 1'b0, 8'h00, 1'b1, 0};
        vecs[5] = '{8'hF0, 16'd50,  5, 2, 1'b0, 8'h00, 1'b0, 2};
        vecs[6] = '{8'h77, 16'd40,  2, 7, 1'b0, 8'hFF, 1'b0, 0};

        rst_n = 1'b0; start = 1'b0; challenge = 8'h00; win_len = 16'd0;
        resp_ready = 1'b0; sat_clr = 1'b0; sat_en = 1'b0; sat_ro = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ro_en", ro_en, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", resp, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_tie", tie, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset during MEASURE of bit 3
        per_a = 2; per_b = 5; same = 1'b0; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        base = en_rises;
        challenge = 8'h12; win_len = 16'd100; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (en_rises < base + 4 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_bit3", (en_rises >= base + 4), 1);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ro_en", ro_en, 0);
        chk("mid_rst_sel_a", sel_a, 0);
        chk("mid_rst_sel_b", sel_b, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_resp", resp, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_tie", tie, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid || busy) bad++;
        end
        chk("no_resp_after_reset", bad, 0);
        run_vec(vecs[3]);

        // Saturating counter: no increments while disabled
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        chk("sat_cleared", sat_count, 0);
        for (int i = 0; i < 12; i++) begin
            sat_ro = ~sat_ro;
            @(posedge clk);
            #1;
        end
        chk("sat_disabled_hold", sat_count, 0);
        // Saturating counter: ~30 edges into a 4-bit counter
        sat_en  = 1'b1;
        wrapped = 1'b0;
        prev    = sat_count;
        for (int i = 0; i < 60; i++) begin
            sat_ro = ~sat_ro;
            @(posedge clk);
            #1;
            if (sat_count < prev) wrapped = 1'b1;
            prev = sat_count;
        end
        chk("sat_count", sat_count, 4'hF);
        chk("sat_no_wrap", wrapped, 0);
        sat_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
